// File: rtl/im_load_ctrl_if.sv
// Fetch, loader-stream and instruction-memory port signals of the load controller.
// The slave modport is the controller side; master is the surrounding fabric.
interface im_load_ctrl_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              ld_valid;
    logic [31:0]       ld_data;
    logic              ld_ready;
    logic [31:0]       fetch_pc;
    logic [31:0]       fetch_instr;
    logic [31:0]       im_rdata;
    logic [ADDR_W-1:0] im_addr;
    logic              im_we;
    logic [31:0]       im_wdata;

    modport master (
        output ld_valid, ld_data, fetch_pc, im_rdata,
        input  ld_ready, fetch_instr, im_addr, im_we, im_wdata
    );

    modport slave (
        input  ld_valid, ld_data, fetch_pc, im_rdata,
        output ld_ready, fetch_instr, im_addr, im_we, im_wdata
    );
endinterface

// File: rtl/im_load_ctrl.sv
// Instruction-memory port sequencer: serves fetch reads in RUN, and on request drains
// the CPU, streams a program in, NOP-fills the remainder and pulses a CPU reset.
module im_load_ctrl #(
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    output logic              cpu_stall,
    output logic              cpu_rst,
    output logic              busy,
    output logic              load_done,
    im_load_ctrl_if.slave     bus
);

    localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam int unsigned PTR_W = ADDR_W + 1;

    localparam logic [PTR_W-1:0] DEPTH_P   = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_P    = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] ONE_P     = PTR_W'(1);
    localparam logic [CNT_W-1:0] DRAIN_INI = CNT_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_DRAIN,
        ST_LOAD,
        ST_FILL,
        ST_RELEASE
    } state_t;

    state_t           state, state_n;
    logic [PTR_W-1:0] wptr,  wptr_n;
    logic [PTR_W-1:0] len,   len_n;
    logic [CNT_W-1:0] cnt,   cnt_n;

    // State and sequencing registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
            wptr  <= '0;
            len   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            wptr  <= wptr_n;
            len   <= len_n;
            cnt   <= cnt_n;
        end
    end

    // Next state and port muxing; the stall is the default outside RUN
    always_comb begin
        state_n         = state;
        wptr_n          = wptr;
        len_n           = len;
        cnt_n           = cnt;
        cpu_stall       = 1'b1;
        cpu_rst         = 1'b0;
        busy            = 1'b1;
        load_done       = 1'b0;
        bus.ld_ready    = 1'b0;
        bus.im_we       = 1'b0;
        bus.im_wdata    = '0;
        bus.im_addr     = bus.fetch_pc[ADDR_W-1:0];
        bus.fetch_instr = '0;

        unique case (state)
            ST_RUN: begin
                cpu_stall = 1'b0;
                busy      = 1'b0;
                // Addresses beyond the memory read back as NOP
                if (bus.fetch_pc < 32'(DEPTH)) begin
                    bus.fetch_instr = bus.im_rdata;
                end
                if (load_start) begin
                    len_n   = (load_len > DEPTH_P) ? DEPTH_P : load_len;
                    wptr_n  = '0;
                    cnt_n   = DRAIN_INI;
                    state_n = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                cnt_n = cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    state_n = (len != '0) ? ST_LOAD : ST_FILL;
                end
            end

            ST_LOAD: begin
                bus.ld_ready = 1'b1;
                bus.im_addr  = wptr[ADDR_W-1:0];
                bus.im_wdata = bus.ld_data;
                bus.im_we    = bus.ld_valid;
                if (bus.ld_valid) begin
                    wptr_n = wptr + ONE_P;
                    if (wptr == len - ONE_P) begin
                        state_n = (len < DEPTH_P) ? ST_FILL : ST_RELEASE;
                    end
                end
            end

            ST_FILL: begin
                bus.im_we   = 1'b1;
                bus.im_addr = wptr[ADDR_W-1:0];
                wptr_n      = wptr + ONE_P;
                if (wptr == LAST_P) begin
                    state_n = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                cpu_rst   = 1'b1;
                load_done = 1'b1;
                state_n   = ST_RUN;
            end

            default: begin
                state_n = ST_RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_im_load_ctrl.sv
// Bench for im_load_ctrl: randomized program loads checked cycle by cycle against a
// phase-level model, plus a memory image comparison after each load.
module tb_im_load_ctrl;

    localparam int unsigned DEPTH  = 256;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DRAIN  = 3;
    localparam int unsigned VEC_W  = 6 + ADDR_W + 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_start;
    logic [ADDR_W:0]   load_len;
    logic              cpu_stall, cpu_rst, busy, load_done;
    logic              mem_init;

    logic [31:0] imem    [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    int checks = 0;
    int errors = 0;

    im_load_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    im_load_ctrl #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk(clk), .reset(reset), .load_start(load_start), .load_len(load_len),
        .cpu_stall(cpu_stall), .cpu_rst(cpu_rst), .busy(busy), .load_done(load_done),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Writable instruction memory with combinational read
    assign bus.im_rdata = imem[bus.im_addr];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) imem[i] <= (i == 5) ? 32'h40042000 : 32'h0;
        end else if (bus.im_we) begin
            imem[bus.im_addr] <= bus.im_wdata;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [VEC_W-1:0] obs_vec();
        return {busy, cpu_stall, cpu_rst, load_done, bus.ld_ready, bus.im_we,
                bus.im_addr, bus.im_wdata, bus.fetch_instr};
    endfunction

    // Outputs expected while the CPU owns the memory
    function automatic logic [VEC_W-1:0] exp_run(input logic [31:0] pc);
        logic [31:0] fi;
        fi = (pc < DEPTH) ? ref_mem[pc[ADDR_W-1:0]] : 32'h0;
        return {6'b000000, pc[ADDR_W-1:0], 32'h0, fi};
    endfunction

    task automatic run_phase(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            bus.fetch_pc = (k == 0) ? 32'd256 : 32'($urandom_range(0, 511));
            bus.ld_valid = 1'($urandom_range(0, 1));
            bus.ld_data  = $urandom;
            load_start   = 1'b0;
            #1;
            check($sformatf("%s_run%0d", tag, k), obs_vec(), exp_run(bus.fetch_pc));
            @(posedge clk); #1;
        end
    endtask

    // One full load; entered and left just after a rising edge
    task automatic run_load(input int req_len, input int gap_pct, input bit poke);
        int eff;
        int acc = 0;
        int fillk = 0;
        int c = 0;
        bit done = 1'b0;
        logic [31:0] words [$];
        logic [VEC_W-1:0] e;
        logic [ADDR_W-1:0] pc8;

        eff = (req_len > DEPTH) ? DEPTH : req_len;
        for (int i = 0; i < eff; i++) words.push_back($urandom);
        bus.fetch_pc = 32'($urandom_range(0, 300));
        pc8          = bus.fetch_pc[ADDR_W-1:0];
        bus.ld_valid = 1'b0;
        load_len     = (ADDR_W + 1)'(req_len);
        load_start   = 1'b1;
        @(posedge clk); #1;

        while (!done && c < 4 * DEPTH) begin
            load_start   = poke && (c < DRAIN + 4);
            bus.ld_data  = $urandom;
            bus.ld_valid = 1'b0;
            if (c < DRAIN) begin
                bus.ld_valid = 1'($urandom_range(0, 1));
            end else if (acc < eff && $urandom_range(0, 99) >= gap_pct) begin
                bus.ld_valid = 1'b1;
                bus.ld_data  = words[acc];
            end
            #1;
            if (c < DRAIN) begin
                e = {6'b110000, pc8, 32'h0, 32'h0};
            end else if (acc < eff) begin
                e = {5'b11001, bus.ld_valid, ADDR_W'(acc), bus.ld_data, 32'h0};
                if (bus.ld_valid) acc++;
            end else if (fillk < DEPTH - eff) begin
                e = {6'b110001, ADDR_W'(eff + fillk), 32'h0, 32'h0};
                fillk++;
            end else begin
                e = {6'b111100, pc8, 32'h0, 32'h0};
                done = 1'b1;
            end
            check($sformatf("load%0d_c%0d", req_len, c), obs_vec(), e);
            @(posedge clk); #1;
            c++;
        end
        check($sformatf("load%0d_finished", req_len), 128'(done), 128'(1));

        load_start   = 1'b0;
        bus.ld_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = (i < eff) ? words[i] : 32'h0;
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("load%0d_mem%0d", req_len, i), 128'(imem[i]), 128'(ref_mem[i]));
        end
        run_phase(4, $sformatf("after%0d", req_len));
    endtask

    initial begin
        logic [31:0] w0, w1;

        // Reset dominates a simultaneous load request
        reset        = 1'b1;
        mem_init     = 1'b1;
        load_start   = 1'b1;
        load_len     = 9'd3;
        bus.fetch_pc = 32'd5;
        bus.ld_valid = 1'b0;
        bus.ld_data  = 32'h0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        ref_mem[5] = 32'h40042000;
        repeat (2) @(posedge clk);
        #1;
        mem_init = 1'b0;
        check("reset_outputs", obs_vec(), exp_run(32'd5));
        check("reset_fetch_instr", 128'(bus.fetch_instr), 128'(32'h40042000));
        check("reset_im_addr", 128'(bus.im_addr), 128'(8'd5));
        reset      = 1'b0;
        load_start = 1'b0;
        @(posedge clk); #1;
        run_phase(4, "idle");

        run_load(3, 0, 1'b0);
        run_load(2, 70, 1'b0);
        run_load(0, 0, 1'b0);
        run_load(300, 20, 1'b1);
        run_load(256, 0, 1'b0);
        run_load(int'($urandom_range(1, 255)), 30, 1'b1);
        run_load(int'($urandom_range(0, 511)), 40, 1'b1);

        // Reset after two words of a five-word load
        w0 = $urandom;
        w1 = $urandom;
        bus.fetch_pc = 32'd1;
        load_len     = 9'd5;
        load_start   = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        repeat (DRAIN) begin
            @(posedge clk); #1;
        end
        bus.ld_valid = 1'b1;
        bus.ld_data  = w0;
        @(posedge clk); #1;
        bus.ld_data = w1;
        @(posedge clk); #1;
        bus.ld_valid = 1'b0;
        reset        = 1'b1;
        ref_mem[0]   = w0;
        ref_mem[1]   = w1;
        #1;
        check("midreset_now", obs_vec(), exp_run(32'd1));
        @(posedge clk); #1;
        check("midreset_next", obs_vec(), exp_run(32'd1));
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("midreset_mem%0d", i), 128'(imem[i]), 128'(ref_mem[i]));
        end
        run_phase(6, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
